// File: rtl/bin_to_bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
//  bin_to_bcd_seq_pkg
//  Types and constants shared by the sequential binary-to-BCD converter:
//  state enumeration, BCD digit width and a counter sizing helper.
//  Revision: 1.0 - initial release
// ============================================================================
package bin_to_bcd_seq_pkg;

`include "display_defs.vh"

   localparam int c_bcd_w = `DISP_BCD_W;

   typedef enum logic [1:0] {
      S_IDLE  = `DISP_ST_IDLE,
      S_SHIFT = `DISP_ST_SHIFT,
      S_DONE  = `DISP_ST_DONE
   } state_t;

   // Smallest bit count that can represent 'value' (at least 1 bit).
   function automatic int cnt_bits(input int value);
      int n;
      n = 1;
      for (int i = 1; i < 32; i++) begin
         if ((longint'(1) << i) <= longint'(value)) begin
            n = i + 1;
         end
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd_seq_add3.sv
`default_nettype none
// ============================================================================
//  bcd_add3
//  Double-dabble digit correction: adds 3 to a BCD digit when it is >= 5,
//  so the following left shift carries correctly into the next digit.
//  Ports:
//    din   in   4  working BCD digit
//    dout  out  4  corrected digit
//  Revision: 1.0 - initial release
// ============================================================================
module bcd_add3
   import bin_to_bcd_seq_pkg::*;
(
   input  logic [c_bcd_w-1:0] din,
   output logic [c_bcd_w-1:0] dout
);

   localparam logic [c_bcd_w-1:0] c_five  = c_bcd_w'(5);
   localparam logic [c_bcd_w-1:0] c_three = c_bcd_w'(3);

   assign dout = (din >= c_five) ? (din + c_three) : din;

endmodule
`default_nettype wire

// File: rtl/display_defs.vh
`default_nettype none
// ============================================================================
//  display_defs.vh
//  Shared encodings for the BCD display path: FSM state codes and the width
//  of one BCD digit. Pulled in by bin_to_bcd_seq_pkg.
//  Revision: 1.0 - initial release
// ============================================================================
`ifndef DISPLAY_DEFS_VH
`define DISPLAY_DEFS_VH

`define DISP_ST_IDLE  2'd0
`define DISP_ST_SHIFT 2'd1
`define DISP_ST_DONE  2'd2

`define DISP_BCD_W    4

`endif
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  bin_to_bcd_seq
//  Sequential binary-to-BCD converter (shift-add-3, MSB first, one bit per
//  clock). A conversion takes WIDTH+2 cycles from accepted start to the
//  next possible start; done pulses for one cycle when results update.
//  Optional feature macro: BIN_TO_BCD_SEQ_BLANK_EN adds the 'blank'
//  leading-zero mask output.
//  Ports:
//    clk       in   1         system clock, rising edge
//    reset     in   1         asynchronous active-high reset
//    start     in   1         conversion request, honoured only when idle
//    entrada   in   WIDTH     unsigned binary value, captured on start
//    busy      out  1         conversion in progress
//    done      out  1         one-cycle pulse, results updated
//    digitos   out  4*DIGITS  BCD result, digit 0 in bits [3:0]
//    overflow  out  1         captured value was >= 10^DIGITS
//    blank     out  DIGITS    leading-zero mask (macro-enabled only)
//  Revision: 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
   import bin_to_bcd_seq_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
)
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [WIDTH-1:0]            entrada,
   output logic                        busy,
   output logic                        done,
   output logic [c_bcd_w*DIGITS-1:0]   digitos,
   output logic                        overflow
`ifdef BIN_TO_BCD_SEQ_BLANK_EN
   ,
   output logic [DIGITS-1:0]           blank
`endif
);

   localparam int                 c_bcd_bits = c_bcd_w * DIGITS;
   localparam int                 c_cnt_w    = cnt_bits(WIDTH);
   localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WIDTH);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   state_t                  r_state;
   logic [WIDTH-1:0]        r_shift;
   logic [c_bcd_bits-1:0]   r_bcd;
   logic [c_bcd_bits-1:0]   w_adj;
   logic [c_cnt_w-1:0]      r_cnt;
   logic                    r_ovf;
   logic                    r_busy;
   logic                    r_done;
   logic [c_bcd_bits-1:0]   r_digitos;
   logic                    r_overflow;

   // One add-3 corrector per working digit; all digits are corrected in
   // parallel before the shift.
   generate
      for (genvar k = 0; k < DIGITS; k++) begin : g_digit
         bcd_add3 u_add3 (
            .din  (r_bcd[k*c_bcd_w +: c_bcd_w]),
            .dout (w_adj[k*c_bcd_w +: c_bcd_w])
         );
      end
   endgenerate

`ifdef BIN_TO_BCD_SEQ_BLANK_EN
   logic [DIGITS-1:0] w_blank;
   logic [DIGITS-1:0] r_blank;
   logic              w_zero_hi;

   // Walk from the top digit down; a digit is blanked while it and every
   // digit above it are zero. Digit 0 always stays visible.
   always_comb begin
      w_blank   = '0;
      w_zero_hi = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         w_zero_hi  = w_zero_hi & (r_bcd[k*c_bcd_w +: c_bcd_w] == '0);
         w_blank[k] = w_zero_hi;
      end
   end

   assign blank = r_blank;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_ovf      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_digitos  <= '0;
         r_overflow <= 1'b0;
`ifdef BIN_TO_BCD_SEQ_BLANK_EN
         r_blank    <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_shift <= entrada;
                  r_bcd   <= '0;
                  r_cnt   <= c_cnt_load;
                  r_ovf   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               // The bit leaving the top digit is dropped, which keeps the
               // digits at value mod 10^DIGITS; any dropped 1 means the
               // value did not fit.
               r_bcd   <= {w_adj[c_bcd_bits-2:0], r_shift[WIDTH-1]};
               r_shift <= r_shift << 1;
               r_ovf   <= r_ovf | w_adj[c_bcd_bits-1];
               r_cnt   <= r_cnt - c_cnt_one;
               if (r_cnt == c_cnt_one) begin
                  r_state <= S_DONE;
               end
            end

            S_DONE: begin
               r_digitos  <= r_bcd;
               r_overflow <= r_ovf;
`ifdef BIN_TO_BCD_SEQ_BLANK_EN
               r_blank    <= w_blank;
`endif
               r_done     <= 1'b1;
               r_busy     <= 1'b0;
               r_state    <= S_IDLE;
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign digitos  = r_digitos;
   assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  tb_bin_to_bcd_seq
//  Directed self-checking bench for bin_to_bcd_seq. Three instances share
//  clock and reset: 8-bit/3-digit, 10-bit/3-digit and 1-bit/1-digit.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        reset;

   logic        start8, busy8, done8, ovf8;
   logic [7:0]  ent8;
   logic [11:0] dig8;
   logic        start10, busy10, done10, ovf10;
   logic [9:0]  ent10;
   logic [11:0] dig10;
   logic        start1, busy1, done1, ovf1;
   logic [0:0]  ent1;
   logic [3:0]  dig1;
`ifdef BIN_TO_BCD_SEQ_BLANK_EN
   logic [2:0]  blank8;
   logic [2:0]  blank10;
   logic [0:0]  blank1;
`endif

   int total = 0;
   int bad   = 0;
   int ndone8 = 0;
   int nstart8 = 0;
   logic [11:0] exp8_last;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .entrada(ent8),
      .busy(busy8), .done(done8), .digitos(dig8), .overflow(ovf8)
`ifdef BIN_TO_BCD_SEQ_BLANK_EN
      , .blank(blank8)
`endif
   );

   bin_to_bcd_seq #(.WIDTH(10), .DIGITS(3)) dut10 (
      .clk(clk), .reset(reset), .start(start10), .entrada(ent10),
      .busy(busy10), .done(done10), .digitos(dig10), .overflow(ovf10)
`ifdef BIN_TO_BCD_SEQ_BLANK_EN
      , .blank(blank10)
`endif
   );

   bin_to_bcd_seq #(.WIDTH(1), .DIGITS(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .entrada(ent1),
      .busy(busy1), .done(done1), .digitos(dig1), .overflow(ovf1)
`ifdef BIN_TO_BCD_SEQ_BLANK_EN
      , .blank(blank1)
`endif
   );

   // Count done pulses of the 8-bit instance (value just before each edge).
   always @(posedge clk) begin
      if (done8 === 1'b1) ndone8++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] ref3(input int v);
      int m;
      m = v % 1000;
      return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   function automatic logic [2:0] ref_blank(input logic [11:0] d);
      logic [2:0] b;
      b[0] = 1'b0;
      b[2] = (d[11:8] == 4'd0);
      b[1] = b[2] && (d[7:4] == 4'd0);
      return b;
   endfunction

   // Full conversion on the 8-bit instance with latency, hold and pulse checks.
   task automatic run8(input logic [7:0] v, input string tag);
      int lat;
      @(negedge clk);
      ent8 = v; start8 = 1'b1; nstart8++;
      @(negedge clk);
      start8 = 1'b0; ent8 = ~v;
      lat = 1;
      chk({tag, "_busy"}, busy8, 1);
      chk({tag, "_hold"}, dig8, exp8_last);
      while (done8 !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, lat, 10);
      chk({tag, "_dig"}, dig8, ref3(v));
      chk({tag, "_ovf"}, ovf8, 0);
      chk({tag, "_idle"}, busy8, 0);
`ifdef BIN_TO_BCD_SEQ_BLANK_EN
      chk({tag, "_blank"}, blank8, ref_blank(ref3(v)));
`endif
      exp8_last = ref3(v);
      @(negedge clk);
      chk({tag, "_pulse"}, done8, 0);
   endtask

   task automatic run10(input logic [9:0] v, input logic [11:0] ed, input logic eo, input string tag);
      int lat;
      @(negedge clk);
      ent10 = v; start10 = 1'b1;
      @(negedge clk);
      start10 = 1'b0; ent10 = ~v;
      lat = 1;
      while (done10 !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, lat, 12);
      chk({tag, "_dig"}, dig10, ed);
      chk({tag, "_ovf"}, ovf10, eo);
   endtask

   task automatic run1(input logic v, input logic [3:0] ed, input string tag);
      int lat;
      @(negedge clk);
      ent1 = v; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; ent1 = ~v;
      lat = 1;
      while (done1 !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, lat, 3);
      chk({tag, "_dig"}, dig1, ed);
      chk({tag, "_ovf"}, ovf1, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int d0;
      int s0;
      reset = 1'b1;
      start8 = 1'b0; ent8 = '0;
      start10 = 1'b0; ent10 = '0;
      start1 = 1'b0; ent1 = '0;
      exp8_last = '0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_dig", dig8, 0);
      chk("rst_ovf", ovf8, 0);
      chk("rst_busy10", busy10, 0);
      chk("rst_dig1", dig1, 0);
`ifdef BIN_TO_BCD_SEQ_BLANK_EN
      chk("rst_blank", blank8, 0);
`endif
      reset = 1'b0;

      // Basic conversions
      run8(8'd255, "v255");
      run8(8'd0, "v0");
`ifdef BIN_TO_BCD_SEQ_BLANK_EN
      chk("v0_blank110", blank8, 3'b110);
`endif
      run8(8'd99, "v99");

      // Width boundary: 10-bit input into 3 digits
      run10(10'd1000, 12'h000, 1'b1, "w1000");
      run10(10'd999, 12'h999, 1'b0, "w999");
      run10(10'd1023, 12'h023, 1'b1, "w1023");

      // WIDTH=1 single shift cycle
      run1(1'b1, 4'h1, "b1");
      run1(1'b0, 4'h0, "b0");

      // start held high with new data during a conversion of 7
      @(negedge clk);
      d0 = ndone8;
      ent8 = 8'd7; start8 = 1'b1;
      @(negedge clk);
      ent8 = 8'd42;
      lat = 1;
      while (done8 !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      start8 = 1'b0;
      chk("hold_lat", lat, 10);
      chk("hold_dig", dig8, 12'h007);
      repeat (3) @(negedge clk);
      chk("hold_ndone", ndone8 - d0, 1);
      exp8_last = 12'h007;
      run8(8'd42, "v42");

      // Reset during the 4th shift cycle
      @(negedge clk);
      ent8 = 8'd200; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      d0 = ndone8;
      chk("abort_busy_pre", busy8, 1);
      reset = 1'b1;
      #1;
      chk("abort_busy", busy8, 0);
      chk("abort_dig", dig8, 0);
      chk("abort_ovf", ovf8, 0);
      chk("abort_done", done8, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      chk("abort_nodone", ndone8 - d0, 0);
      chk("abort_idle", busy8, 0);
      exp8_last = '0;
      run8(8'd128, "v128");

      // Exhaustive 8-bit sweep
      s0 = nstart8;
      d0 = ndone8;
      for (int v = 0; v < 256; v++) begin
         run8(8'(v), $sformatf("sw%0d", v));
      end
      @(negedge clk);
      chk("sweep_ndone", ndone8 - d0, 256);
      chk("sweep_nstart", nstart8 - s0, 256);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
